// File: rtl/ysyx_24100012_lsu.sv
// ysyx_24100012_lsu: load/store initiator between the core execute stage and data memory.
//   Accepts one request at a time (req_*), issues a word-aligned valid/ready memory
//   transaction with byte strobes (mem_*), waits for the memory response (mem_rsp_*),
//   then returns aligned, extended load data to the core (rsp_*).
//   Ports: clk/rst (sync, active-high); req_valid/req_ready/req_wen/req_size/req_sign/
//   req_addr/req_wdata from the core; rsp_valid/rsp_ready/rsp_rdata/rsp_err to the core;
//   mem_valid/mem_ready/mem_wen/mem_addr/mem_wstrb/mem_wdata request channel;
//   mem_rsp_valid/mem_rsp_ready/mem_rdata response channel.
//   Macro LSU_MISALIGN_CHECK_EN: when defined, misaligned half/word accesses return
//   rsp_err=1 without touching memory; when undefined, the low address bits are forced
//   to natural alignment and rsp_err is always 0.
module ysyx_24100012_lsu #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [1:0]            req_size,
    input  logic                  req_sign,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_wstrb,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_rsp_valid,
    output logic                  mem_rsp_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t                state, state_nx;
    logic                  wen_q, sign_q;
    logic [1:0]            size_q, off_q, off;
    logic                  mis, is_half, is_word;
    logic [3:0]            strb;
    logic [DATA_WIDTH-1:0] lanes, shifted, ext, result;

    assign is_half = req_size == 2'd1;
    assign is_word = req_size[1];

`ifdef LSU_MISALIGN_CHECK_EN
    assign mis = (is_half && req_addr[0]) || (is_word && req_addr[1:0] != 2'b00);
    assign off = req_addr[1:0];
`else
    // Without the check, silently round down to the natural alignment of the size.
    assign mis = 1'b0;
    assign off = is_word ? 2'b00 : is_half ? {req_addr[1], 1'b0} : req_addr[1:0];
`endif

    assign req_ready     = (state == IDLE) && !rst;
    assign mem_valid     = state == REQ;
    assign mem_rsp_ready = state == WAIT;
    assign rsp_valid     = state == RESP;

    always_comb begin
        strb    = !req_wen ? 4'b0000 : req_size == 2'd0 ? 4'b0001 << off :
                  is_half ? 4'b0011 << off : 4'b1111;
        lanes   = !req_wen ? '0 : req_size == 2'd0 ? {4{req_wdata[7:0]}} :
                  is_half ? {2{req_wdata[15:0]}} : req_wdata;
        shifted = mem_rdata >> {off_q, 3'b000};
        ext     = size_q == 2'd0 ? {{24{sign_q & shifted[7]}}, shifted[7:0]} :
                  size_q == 2'd1 ? {{16{sign_q & shifted[15]}}, shifted[15:0]} : shifted;
        result  = wen_q ? '0 : ext;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: state_nx = req_valid ? (mis ? RESP : REQ) : IDLE;
            REQ:  state_nx = mem_ready ? WAIT : REQ;
            WAIT: state_nx = mem_rsp_valid ? RESP : WAIT;
            RESP: state_nx = rsp_ready ? IDLE : RESP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wen_q     <= 1'b0;
            sign_q    <= 1'b0;
            size_q    <= 2'd0;
            off_q     <= 2'd0;
            mem_wen   <= 1'b0;
            mem_addr  <= '0;
            mem_wstrb <= 4'b0000;
            mem_wdata <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req_valid) begin
                wen_q     <= req_wen;
                sign_q    <= req_sign;
                size_q    <= req_size;
                off_q     <= off;
                mem_wen   <= req_wen;
                mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                mem_wstrb <= strb;
                mem_wdata <= lanes;
                rsp_rdata <= '0;
                rsp_err   <= mis;
            end
            if (state == WAIT && mem_rsp_valid) rsp_rdata <= result;
        end
    end
endmodule

// File: tb/tb_ysyx_24100012_lsu.sv
// tb_ysyx_24100012_lsu: directed self-checking bench for the load/store initiator.
module tb_ysyx_24100012_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wen, req_sign;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_valid, mem_ready, mem_wen;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rsp_valid, mem_rsp_ready;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;
    int hs = 0;
    int hs0;

    ysyx_24100012_lsu dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_size(req_size), .req_sign(req_sign), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_valid && mem_ready) hs <= hs + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic wen, input logic [1:0] size, input logic sign,
                          input logic [31:0] addr, input logic [31:0] wd);
        req_wen = wen; req_size = size; req_sign = sign; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    // Memory and core always ready: response expected exactly three cycles after accept.
    task automatic fast(input string tag, input logic wen, input logic [1:0] size,
                        input logic sign, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd, input logic [31:0] e_addr,
                        input logic [3:0] e_strb, input logic [31:0] e_wdata,
                        input logic [31:0] e_rdata);
        mem_ready = 1'b1; mem_rsp_valid = 1'b1; rsp_ready = 1'b1; mem_rdata = rd;
        do_req(wen, size, sign, addr, wd);
        chk({tag, ".c1.mem_valid"}, 32'(mem_valid), 32'd1);
        chk({tag, ".c1.mem_addr"}, mem_addr, e_addr);
        chk({tag, ".c1.mem_wen"}, 32'(mem_wen), 32'(wen));
        chk({tag, ".c1.mem_wstrb"}, 32'(mem_wstrb), 32'(e_strb));
        if (wen) chk({tag, ".c1.mem_wdata"}, mem_wdata, e_wdata);
        chk({tag, ".c1.req_ready"}, 32'(req_ready), 32'd0);
        tick();
        chk({tag, ".c2.mem_rsp_ready"}, 32'(mem_rsp_ready), 32'd1);
        chk({tag, ".c2.rsp_valid"}, 32'(rsp_valid), 32'd0);
        tick();
        chk({tag, ".c3.rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, ".c3.rsp_rdata"}, rsp_rdata, e_rdata);
        chk({tag, ".c3.rsp_err"}, 32'(rsp_err), 32'd0);
        tick();
        chk({tag, ".c4.rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".c4.req_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_size = 2'd0; req_sign = 1'b0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b0; mem_ready = 1'b0;
        mem_rsp_valid = 1'b0; mem_rdata = '0;
        tick();
        tick();
        chk("rst.req_ready", 32'(req_ready), 32'd0);
        chk("rst.mem_valid", 32'(mem_valid), 32'd0);
        chk("rst.mem_rsp_ready", 32'(mem_rsp_ready), 32'd0);
        chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.rsp_err", 32'(rsp_err), 32'd0);
        chk("rst.mem_wen", 32'(mem_wen), 32'd0);
        chk("rst.rsp_rdata", rsp_rdata, 32'd0);
        chk("rst.mem_addr", mem_addr, 32'd0);
        chk("rst.mem_wdata", mem_wdata, 32'd0);
        chk("rst.mem_wstrb", 32'(mem_wstrb), 32'd0);
        rst = 1'b0;
        #1;
        chk("idle.req_ready", 32'(req_ready), 32'd1);

        fast("sw", 1'b1, 2'd2, 1'b0, 32'h80000004, 32'hDEADBEEF, 32'h11111111,
             32'h80000004, 4'b1111, 32'hDEADBEEF, 32'h0);
        fast("lb_s", 1'b0, 2'd0, 1'b1, 32'h80000003, 32'h0, 32'h80AABBCC,
             32'h80000000, 4'b0000, 32'h0, 32'hFFFFFF80);
        fast("lb_u", 1'b0, 2'd0, 1'b0, 32'h80000003, 32'h0, 32'h80AABBCC,
             32'h80000000, 4'b0000, 32'h0, 32'h00000080);
        fast("lh_s", 1'b0, 2'd1, 1'b1, 32'h80000002, 32'h0, 32'h9234F00D,
             32'h80000000, 4'b0000, 32'h0, 32'hFFFF9234);
        fast("lh_u", 1'b0, 2'd1, 1'b0, 32'h80000000, 32'h0, 32'h9234F00D,
             32'h80000000, 4'b0000, 32'h0, 32'h0000F00D);
        fast("sh", 1'b1, 2'd1, 1'b0, 32'h80000002, 32'h0000ABCD, 32'h0,
             32'h80000000, 4'b1100, 32'hABCDABCD, 32'h0);
        fast("sb", 1'b1, 2'd0, 1'b0, 32'h80000001, 32'h1234565A, 32'h0,
             32'h80000000, 4'b0010, 32'h5A5A5A5A, 32'h0);
        fast("lb_s1", 1'b0, 2'd0, 1'b1, 32'h80000001, 32'h0, 32'h80AABBCC,
             32'h80000000, 4'b0000, 32'h0, 32'hFFFFFFBB);

        // Backpressure on every channel.
        mem_ready = 1'b0; mem_rsp_valid = 1'b0; rsp_ready = 1'b0;
        hs0 = hs;
        do_req(1'b0, 2'd2, 1'b0, 32'h80000010, 32'h0);
        for (int i = 0; i < 5; i++) begin
            chk("bp.req.mem_valid", 32'(mem_valid), 32'd1);
            chk("bp.req.mem_addr", mem_addr, 32'h80000010);
            chk("bp.req.mem_wen", 32'(mem_wen), 32'd0);
            chk("bp.req.mem_wstrb", 32'(mem_wstrb), 32'd0);
            chk("bp.req.req_ready", 32'(req_ready), 32'd0);
            tick();
        end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("bp.wait.mem_rsp_ready", 32'(mem_rsp_ready), 32'd1);
            chk("bp.wait.mem_valid", 32'(mem_valid), 32'd0);
            chk("bp.wait.rsp_valid", 32'(rsp_valid), 32'd0);
            chk("bp.wait.req_ready", 32'(req_ready), 32'd0);
            tick();
        end
        mem_rsp_valid = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick();
        mem_rsp_valid = 1'b0; mem_rdata = 32'h0BADBEEF;
        for (int i = 0; i < 3; i++) begin
            chk("bp.resp.rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp.resp.rsp_rdata", rsp_rdata, 32'hCAFEF00D);
            chk("bp.resp.rsp_err", 32'(rsp_err), 32'd0);
            chk("bp.resp.req_ready", 32'(req_ready), 32'd0);
            chk("bp.resp.mem_rsp_ready", 32'(mem_rsp_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp.done.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("bp.done.req_ready", 32'(req_ready), 32'd1);
        chk("bp.mem_handshakes", 32'(hs - hs0), 32'd1);

        // Misaligned word load.
`ifdef LSU_MISALIGN_CHECK_EN
        mem_ready = 1'b1; mem_rsp_valid = 1'b1; rsp_ready = 1'b1; mem_rdata = 32'h12345678;
        hs0 = hs;
        do_req(1'b0, 2'd2, 1'b0, 32'h80000002, 32'h0);
        chk("mis.mem_valid", 32'(mem_valid), 32'd0);
        chk("mis.rsp_valid", 32'(rsp_valid), 32'd1);
        chk("mis.rsp_err", 32'(rsp_err), 32'd1);
        chk("mis.rsp_rdata", rsp_rdata, 32'd0);
        tick();
        chk("mis.done.req_ready", 32'(req_ready), 32'd1);
        chk("mis.mem_handshakes", 32'(hs - hs0), 32'd0);
`else
        fast("lw_mis", 1'b0, 2'd2, 1'b0, 32'h80000002, 32'h0, 32'h12345678,
             32'h80000000, 4'b0000, 32'h0, 32'h12345678);
`endif

        // Reset during WAIT; stray response afterwards must be ignored.
        mem_ready = 1'b1; mem_rsp_valid = 1'b0; rsp_ready = 1'b0;
        do_req(1'b0, 2'd2, 1'b0, 32'h80000020, 32'h0);
        tick();
        chk("rw.wait.mem_rsp_ready", 32'(mem_rsp_ready), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem_rsp_valid = 1'b1; mem_rdata = 32'hFFFFFFFF;
        #1;
        chk("rw.mem_valid", 32'(mem_valid), 32'd0);
        chk("rw.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rw.mem_rsp_ready", 32'(mem_rsp_ready), 32'd0);
        chk("rw.req_ready", 32'(req_ready), 32'd1);
        chk("rw.mem_addr", mem_addr, 32'd0);
        tick();
        mem_rsp_valid = 1'b0;
        chk("rw.stray.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rw.stray.mem_valid", 32'(mem_valid), 32'd0);
        chk("rw.stray.rsp_rdata", rsp_rdata, 32'd0);
        tick();
        chk("rw.stray2.rsp_valid", 32'(rsp_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ysyx_24100012_lsu.md
Name: ysyx_24100012_lsu

Overview:
Load/store initiator that sits between the core's execute stage and the data-memory responder. It accepts one load/store request at a time and issues a word-aligned valid/ready transaction with byte strobes to memory. It waits a variable number of cycles for the memory response, then returns aligned and extended load data to the core. It is the requester-side counterpart of the DPI-backed data RAM, and replaces direct combinational RAM access by the core.

Parameters:
ADDR_WIDTH, 32, address width in bits
DATA_WIDTH, 32, data width in bits; only 32 is supported (4 byte lanes)

Ports:
clk  in  1  system clock; all logic is on the rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  core request valid
req_ready  out  1  LSU can accept a request
req_wen  in  1  1 = store, 0 = load
req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is reserved and treated as word
req_sign  in  1  loads only: 1 = sign-extend, 0 = zero-extend
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  store data, right-justified
rsp_valid  out  1  response valid to core
rsp_ready  in  1  core accepts the response
rsp_rdata  out  DATA_WIDTH  load result; 0 for stores
rsp_err  out  1  misaligned access (feature-dependent)
mem_valid  out  1  memory request valid
mem_ready  in  1  memory accepts the request
mem_wen  out  1  memory write enable
mem_addr  out  ADDR_WIDTH  word-aligned address ({addr[31:2],2'b00})
mem_wstrb  out  4  byte-lane strobes
mem_wdata  out  DATA_WIDTH  lane-replicated store data
mem_rsp_valid  in  1  memory response valid
mem_rsp_ready  out  1  LSU can take the memory response
mem_rdata  in  DATA_WIDTH  raw memory word

Behaviour:
- States are IDLE, REQ, WAIT and RESP.
- Reset: state goes to IDLE. mem_valid, mem_rsp_ready, rsp_valid, rsp_err and mem_wen are 0; rsp_rdata, mem_addr, mem_wdata and mem_wstrb are 0.
- req_ready = (state==IDLE) && !rst.
- IDLE: on req_valid&&req_ready, register all request fields and compute off = addr[1:0].
  - If the access is misaligned (feature enabled), go to RESP with rsp_err=1 and rsp_rdata=0. No memory access is made.
  - Otherwise go to REQ.
- REQ: mem_valid=1. mem_addr, mem_wen, mem_wstrb and mem_wdata stay stable until mem_valid&&mem_ready, then go to WAIT.
- WAIT: mem_rsp_ready=1. On mem_rsp_valid, form the result and go to RESP.
  - Loads: shifted = mem_rdata >> (off*8), then mask to the size and sign- or zero-extend per req_sign.
  - Stores: result is 0 and mem_rdata is ignored.
- RESP: rsp_valid=1. rsp_rdata and rsp_err stay stable until rsp_ready; on the handshake go to IDLE.
- mem_rsp_valid outside WAIT is ignored (mem_rsp_ready=0).
- Store lane rules:
  - Byte: wstrb = 4'b0001<<off, wdata = {4{wdata[7:0]}}.
  - Half: wstrb = 4'b0011<<off, wdata = {2{wdata[15:0]}}.
  - Word: wstrb = 4'b1111.
- Loads drive wstrb = 0.
- Minimum latency with memory always ready and responding in the same cycle:
  - Request accepted in cycle 0.
  - mem_valid in cycle 1.
  - mem_rsp_valid accepted in cycle 2.
  - rsp_valid in cycle 3.
- Only one transaction is ever outstanding; no new request is accepted until the RESP handshake completes.
- Reset in any state aborts the transaction: the next cycle is IDLE with all outputs at reset values. A memory response that arrives late is ignored.

Optional Feature:
LSU_MISALIGN_CHECK_EN:
- Defined: misaligned accesses (half with addr[0]=1, word with addr[1:0]!=0) produce an error response without any memory access.
- Undefined: rsp_err is tied to 0. Half accesses force off[0]=0 and word accesses force off=0. The memory access always proceeds.

Test Plan:
1. Store word 0xDEADBEEF at 0x80000004, memory always ready -> mem_addr=0x80000004, wstrb=4'b1111, wdata=0xDEADBEEF; rsp_valid in cycle 3 with rdata=0 and err=0.
2. Signed byte load at 0x80000003, mem_rdata=0x80AABBCC -> rsp_rdata=0xFFFFFF80. The same load with req_sign=0 -> 0x00000080.
3. Signed half load at 0x80000002, mem_rdata=0x9234F00D -> 0xFFFF9234. Store half 0xABCD at 0x80000002 -> wstrb=4'b1100, wdata=0xABCDABCD.
4. Backpressure: hold mem_ready low for 5 cycles, mem_rsp_valid low for 4 cycles, rsp_ready low for 3 cycles -> all mem_* and rsp_* outputs stay stable and req_ready stays 0 throughout; exactly one memory transaction occurs.
5. Word load at 0x80000002 -> with the macro: no mem_valid, rsp_err=1 and rdata=0 in the cycle after accept. Without the macro: mem_addr=0x80000000 and the result is the full memory word.
6. Assert rst for 1 cycle during WAIT, then pulse mem_rsp_valid -> next cycle is IDLE with mem_valid, rsp_valid and mem_rsp_ready at 0 and req_ready at 1; the stray response produces no rsp_valid.
